// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator: pattern modes,
// default resolution and the eight-entry bar colour table.
package vga_pkg;

  typedef enum logic [1:0] {
    ModeBars    = 2'd0,
    ModeChecker = 2'd1,
    ModeRamp    = 2'd2,
    ModeScroll  = 2'd3
  } mode_e;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefColW    = 10;
  localparam int unsigned DefRowW    = 9;
  localparam int unsigned DefColorW  = 4;
  localparam int unsigned MaxColorW  = 16;

  // Packed {R,G,B} at the widest supported channel; callers cast down to 3*color_w.
  function automatic logic [3*MaxColorW-1:0] bar_color(input int unsigned color_w,
                                                       input int unsigned idx);
    logic [MaxColorW-1:0] full;
    logic [MaxColorW-1:0] grey;
    logic [MaxColorW-1:0] r;
    logic [MaxColorW-1:0] g;
    logic [MaxColorW-1:0] b;
    full = MaxColorW'((32'd1 << color_w) - 32'd1);
    grey = MaxColorW'(32'd1 << (color_w - 1));
    r = '0;
    g = '0;
    b = '0;
    case (idx % 8)
      0: r = full;
      1: g = full;
      2: b = full;
      3: begin r = full; g = full; end
      4: begin g = full; b = full; end
      5: begin r = full; b = full; end
      6: begin r = full; g = full; b = full; end
      default: begin r = grey; g = grey; b = grey; end
    endcase
    return ((3*MaxColorW)'(r) << (2 * color_w)) | ((3*MaxColorW)'(g) << color_w) |
           (3*MaxColorW)'(b);
  endfunction

endpackage

// File: rtl/vga_bar_index.sv
// Bar index from a column: counts how many bar boundaries the column has reached.
module vga_bar_index #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned NUM_BARS = 8,
  parameter int unsigned COL_W    = 10
) (
  input  logic [COL_W-1:0] col,
  output logic [3:0]       k
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  always_comb begin
    k = '0;
    for (int unsigned j = 1; j < NUM_BARS; j++) begin
      if (col >= COL_W'(j * BAR_W)) begin
        k = k + 4'd1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, checkerboard, grey ramp and scrolling bars,
// with the pattern and scroll offset latched once per frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned COL_W       = DefColW,
  parameter int unsigned ROW_W       = DefRowW,
  parameter int unsigned COLOR_W     = DefColorW,
  parameter int unsigned NUM_BARS    = 8,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned SCROLL_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 de_in,
  input  logic [ROW_W-1:0]     row,
  input  logic [COL_W-1:0]     col,
  input  logic [1:0]           mode_in,
  output logic [3*COLOR_W-1:0] pixel_out,
  output logic                 de_out,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned PIX_W      = 3 * COLOR_W;
  localparam int unsigned RAMP_SHIFT = COL_W - COLOR_W - 1;

  mode_e              mode_q;
  logic [COL_W-1:0]   scroll_q, scroll_d;
  logic [7:0]         frame_cnt_q;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic               de_q;

  logic [COL_W:0]     scroll_sum;
  logic [COL_W:0]     col_sum;
  logic [COL_W-1:0]   col_scr;
  logic [COL_W-1:0]   bar_col;
  logic [3:0]         bar_k;
  logic [COL_W-1:0]   ramp_raw;
  logic [COLOR_W-1:0] ramp;
  logic               active;

  // Both wraps rely on the operands already being below H_ACTIVE, so one subtract suffices.
  always_comb begin
    scroll_sum = {1'b0, scroll_q} + (COL_W+1)'(SCROLL_STEP);
    scroll_d   = (scroll_sum >= (COL_W+1)'(H_ACTIVE)) ?
                 COL_W'(scroll_sum - (COL_W+1)'(H_ACTIVE)) : scroll_sum[COL_W-1:0];
    col_sum    = {1'b0, col} + {1'b0, scroll_q};
    col_scr    = (col_sum >= (COL_W+1)'(H_ACTIVE)) ?
                 COL_W'(col_sum - (COL_W+1)'(H_ACTIVE)) : col_sum[COL_W-1:0];
    bar_col    = (mode_q == ModeScroll) ? col_scr : col;
  end

  vga_bar_index #(
    .H_ACTIVE (H_ACTIVE),
    .NUM_BARS (NUM_BARS),
    .COL_W    (COL_W)
  ) u_bar_index (
    .col (bar_col),
    .k   (bar_k)
  );

  always_comb begin
    ramp_raw = col >> RAMP_SHIFT;
    ramp     = (ramp_raw > COL_W'((1 << COLOR_W) - 1)) ? '1 : ramp_raw[COLOR_W-1:0];
    active   = de_in && ({1'b0, row} < (ROW_W+1)'(V_ACTIVE)) &&
               ({1'b0, col} < (COL_W+1)'(H_ACTIVE));
    pixel_d  = '0;
    if (active) begin
      case (mode_q)
        ModeBars, ModeScroll: pixel_d = PIX_W'(bar_color(COLOR_W, 32'(bar_k)));
        ModeChecker:          pixel_d = (row[CHECK_LOG2] ^ col[CHECK_LOG2]) ? '1 : '0;
        ModeRamp:             pixel_d = {ramp, ramp, ramp};
        default:              pixel_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_q     <= '0;
      de_q        <= 1'b0;
      mode_q      <= ModeBars;
      scroll_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      pixel_q <= pixel_d;
      de_q    <= de_in;
      if (frame_start) begin
        mode_q      <= mode_e'(mode_in);
        scroll_q    <= scroll_d;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign pixel_out = pixel_q;
  assign de_out    = de_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen at default parameters, hand-computed expectations.
module tb_vga_pattern_gen;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        de_in;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [1:0]  mode_in;
  logic [11:0] pixel_out;
  logic        de_out;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] bar_rgb [8];

  vga_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .de_in       (de_in),
    .row         (row),
    .col         (col),
    .mode_in     (mode_in),
    .pixel_out   (pixel_out),
    .de_out      (de_out),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic step(input logic fs, input logic de, input int r, input int c);
    frame_start = fs;
    de_in       = de;
    row         = 9'(r);
    col         = 10'(c);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    bar_rgb = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF, 12'h888};
    rst = 1'b1; frame_start = 1'b0; de_in = 1'b0; row = '0; col = '0; mode_in = 2'd0;

    // Reset state
    step(1'b0, 1'b1, 10, 5);
    check_eq("rst_pixel", 32'(pixel_out), 32'h0);
    check_eq("rst_de", 32'(de_out), 32'h0);
    check_eq("rst_cnt", 32'(frame_cnt), 32'h0);
    rst = 1'b0;

    // Bars
    mode_in = 2'd0;
    pulses(1);
    check_eq("cnt_1", 32'(frame_cnt), 32'd1);
    for (int c = 0; c < 640; c++) begin
      step(1'b0, 1'b1, 10, c);
      check_eq("bars_sweep", 32'(pixel_out), 32'(bar_rgb[c / 80]));
    end
    step(1'b0, 1'b1, 10, 79);
    check_eq("bars_79", 32'(pixel_out), 32'hF00);
    step(1'b0, 1'b1, 10, 80);
    check_eq("bars_80", 32'(pixel_out), 32'h0F0);
    step(1'b0, 1'b1, 10, 560);
    check_eq("bars_560", 32'(pixel_out), 32'h888);

    // Blanking and de_out latency
    step(1'b0, 1'b0, 10, 100);
    check_eq("de0_pixel", 32'(pixel_out), 32'h0);
    check_eq("de0_deout", 32'(de_out), 32'h0);
    de_in = 1'b1;
    #1;
    check_eq("deout_registered", 32'(de_out), 32'h0);
    step(1'b0, 1'b1, 10, 700);
    check_eq("col700_pixel", 32'(pixel_out), 32'h0);
    check_eq("col700_deout", 32'(de_out), 32'h1);
    step(1'b0, 1'b1, 480, 100);
    check_eq("row480_pixel", 32'(pixel_out), 32'h0);
    step(1'b0, 1'b1, 479, 100);
    check_eq("row479_pixel", 32'(pixel_out), 32'h0F0);

    // Checkerboard
    mode_in = 2'd1;
    pulses(1);
    step(1'b0, 1'b1, 0, 31);
    check_eq("chk_r0_c31", 32'(pixel_out), 32'h000);
    step(1'b0, 1'b1, 0, 32);
    check_eq("chk_r0_c32", 32'(pixel_out), 32'hFFF);
    step(1'b0, 1'b1, 32, 32);
    check_eq("chk_r32_c32", 32'(pixel_out), 32'h000);
    step(1'b0, 1'b1, 32, 0);
    check_eq("chk_r32_c0", 32'(pixel_out), 32'hFFF);

    // Ramp
    mode_in = 2'd2;
    pulses(1);
    step(1'b0, 1'b1, 5, 0);
    check_eq("ramp_0", 32'(pixel_out), 32'h000);
    step(1'b0, 1'b1, 5, 32);
    check_eq("ramp_32", 32'(pixel_out), 32'h111);
    step(1'b0, 1'b1, 5, 255);
    check_eq("ramp_255", 32'(pixel_out), 32'h777);
    step(1'b0, 1'b1, 5, 479);
    check_eq("ramp_479", 32'(pixel_out), 32'hEEE);
    step(1'b0, 1'b1, 5, 480);
    check_eq("ramp_480", 32'(pixel_out), 32'hFFF);
    step(1'b0, 1'b1, 5, 639);
    check_eq("ramp_639", 32'(pixel_out), 32'hFFF);

    // Scroll from a fresh reset
    rst = 1'b1;
    step(1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    mode_in = 2'd3;
    pulses(20);
    step(1'b0, 1'b1, 0, 0);
    check_eq("scr80_c0", 32'(pixel_out), 32'h0F0);
    step(1'b0, 1'b1, 0, 559);
    check_eq("scr80_c559", 32'(pixel_out), 32'h888);
    step(1'b0, 1'b1, 0, 560);
    check_eq("scr80_c560_wrap", 32'(pixel_out), 32'hF00);
    pulses(140);
    check_eq("cnt_160", 32'(frame_cnt), 32'd160);
    step(1'b0, 1'b1, 0, 0);
    check_eq("scr0_c0", 32'(pixel_out), 32'hF00);
    step(1'b0, 1'b1, 0, 80);
    check_eq("scr0_c80", 32'(pixel_out), 32'h0F0);

    // Pixel coincident with frame_start uses old scroll, then old mode
    step(1'b1, 1'b1, 0, 79);
    check_eq("fs_old_scroll", 32'(pixel_out), 32'hF00);
    step(1'b0, 1'b1, 0, 79);
    check_eq("fs_new_scroll", 32'(pixel_out), 32'h0F0);
    mode_in = 2'd1;
    step(1'b1, 1'b1, 0, 32);
    check_eq("fs_old_mode", 32'(pixel_out), 32'hF00);
    step(1'b0, 1'b1, 0, 32);
    check_eq("fs_new_mode", 32'(pixel_out), 32'hFFF);
    mode_in = 2'd2;
    step(1'b0, 1'b1, 0, 32);
    check_eq("mode_ignored", 32'(pixel_out), 32'hFFF);
    check_eq("cnt_162", 32'(frame_cnt), 32'd162);

    // Frame counter wrap
    pulses(93);
    check_eq("cnt_255", 32'(frame_cnt), 32'd255);
    pulses(1);
    check_eq("cnt_wrap", 32'(frame_cnt), 32'd0);

    // Reset mid-frame, coincident with frame_start; scroll is 388 after 257 pulses
    mode_in = 2'd3;
    pulses(1);
    step(1'b0, 1'b1, 0, 79);
    check_eq("scr388_c79", 32'(pixel_out), 32'hF0F);
    rst = 1'b1;
    step(1'b1, 1'b1, 0, 79);
    check_eq("midrst_pixel", 32'(pixel_out), 32'h0);
    check_eq("midrst_de", 32'(de_out), 32'h0);
    check_eq("midrst_cnt", 32'(frame_cnt), 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b1, 0, 79);
    check_eq("post_rst_bars", 32'(pixel_out), 32'hF00);
    pulses(1);
    step(1'b0, 1'b1, 0, 79);
    check_eq("post_rst_scroll4", 32'(pixel_out), 32'h0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter COL_W, default 10: column coordinate width.
REQ-004 SHALL have parameter ROW_W, default 9: row coordinate width.
REQ-005 SHALL have parameter COLOR_W, default 4: bits per colour channel; pixel is 3*COLOR_W, packed {R,G,B}.
REQ-006 SHALL have parameter NUM_BARS, default 8, range 2..16: number of vertical bars; bar width BAR_W = H_ACTIVE/NUM_BARS (integer).
REQ-007 SHALL have parameter CHECK_LOG2, default 5: checkerboard square size 2^CHECK_LOG2 pixels.
REQ-008 SHALL have parameter SCROLL_STEP, default 4: scroll advance in pixels per frame, less than H_ACTIVE.
REQ-009 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-010 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-011 SHALL have port frame_start  input  1  one-cycle pulse at start of each frame.
REQ-012 SHALL have port de_in  input  1  current coordinate is a display pixel.
REQ-013 SHALL have port row  input  ROW_W  current line.
REQ-014 SHALL have port col  input  COL_W  current pixel in line.
REQ-015 SHALL have port mode_in  input  2  requested pattern, sampled only on frame_start.
REQ-016 SHALL have port pixel_out  output  3*COLOR_W  registered pixel colour.
REQ-017 SHALL have port de_out  output  1  de_in delayed one cycle.
REQ-018 SHALL have port frame_cnt  output  8  frames since reset, wraps 255->0.

Function
REQ-019 SHALL register pixel_out and de_out with exactly 1-cycle latency from row/col/de_in.
REQ-020 SHALL drive pixel_out = 0 whenever the sampled de_in = 0, or row >= V_ACTIVE, or col >= H_ACTIVE.
REQ-021 Mode 0 (BARS): bar index k = count of thresholds j*BAR_W (j = 1..NUM_BARS-1) with col >= j*BAR_W; colour = table[k mod 8].
REQ-022 Colour table, in index order: red, green, blue, yellow, cyan, magenta, white, grey; full-scale channel = all ones; grey channel = MSB only (4'h8 at COLOR_W=4).
REQ-023 Mode 1 (CHECKER): white if bit CHECK_LOG2 of row XOR bit CHECK_LOG2 of col = 1, else black.
REQ-024 Mode 2 (RAMP): all three channels = min(col >> (COL_W-COLOR_W-1), 2^COLOR_W-1).
REQ-025 Mode 3 (SCROLL): as BARS, using col' = (col + scroll) mod H_ACTIVE in place of col; computed without a divider (single conditional subtract).
REQ-026 On frame_start: mode_q <= mode_in; frame_cnt += 1; scroll <= scroll + SCROLL_STEP, minus H_ACTIVE if the sum >= H_ACTIVE.
REQ-027 scroll SHALL advance in every mode, so SCROLL resumes at the frame-accurate position.
REQ-028 A pixel sampled in the same cycle as frame_start SHALL use the old mode_q and old scroll; new values apply from the next cycle.
REQ-029 mode_in changes between frame_start pulses SHALL have no effect.

Reset
REQ-030 When rst = 1 at a clock edge: pixel_out = 0, de_out = 0, mode_q = 0 (BARS), scroll = 0, frame_cnt = 0.
REQ-031 rst SHALL take priority over a coincident frame_start; a frame interrupted by reset restarts in BARS with scroll 0.

Structure
REQ-032 Package vga_pkg SHALL hold the mode enum (BARS, CHECKER, RAMP, SCROLL), the 8-entry colour table as a function of COLOR_W, and default resolution constants.
REQ-033 Bar-index comparator chain SHALL be sub-module vga_bar_index (inputs col, output k), instantiated once and fed by a mux of col/col'.

Verification
REQ-034 Reset, then mode_in=0 with frame_start; sweep col 0..639, row 10, de_in=1 -> col 79: F00, 80: 0F0, 560: 888, each 1 cycle later.
REQ-035 CHECKER, row=0 -> col 31: 000, col 32: FFF; row=32, col=32 -> 000.
REQ-036 SCROLL: after 20 frame_start pulses, scroll=80 -> col 0: 0F0; after 160 pulses, scroll wraps to 0 -> col 0: F00.
REQ-037 de_in=0, or col=700 -> pixel_out 000; de_out follows de_in with 1-cycle delay.
REQ-038 frame_start coincident with mode_in change and de_in=1 -> that pixel uses the old mode; 256 frames -> frame_cnt wraps to 0; rst mid-frame -> all outputs 0 on the next cycle.
